uart_tx_cfg: RTL
================

// Module: uart_tx_cfg
// PURPOSE
//  Parametrised UART transmitter; successor to the fixed 8N1 transmitter.
//  Serialises one word per frame: start bit, DATA_BITS data bits LSB first, optional parity bit, 1 or 2 stop bits.
//  Sits between a host-side valid/ready source and the tx pin.
//  Optional FIFO buffers words so consecutive frames are sent back-to-back.
// PARAMETERS
//  CLK_FREQ    50000000  clk frequency, Hz
//  BAUD_RATE   9600      line rate, bit/s; BAUD_COUNT = CLK_FREQ/BAUD_RATE clk cycles per bit, must be >= 2 (elaboration error otherwise)
//  DATA_BITS   8         data bits per frame, legal range 5..9
//  PARITY      0         0 = none, 1 = odd, 2 = even
//  STOP_BITS   1         stop bits per frame, 1 or 2
//  FIFO_DEPTH  4         FIFO entries, power of 2 >= 2; used only with UART_TX_FIFO_EN
// PORTS
//  clk      in   1          single clock; all logic on posedge
//  rst_n    in   1          asynchronous, active-low reset
//  data_in  in   DATA_BITS  word to transmit; sampled on accept
//  send     in   1          host valid
//  ready    out  1          block can accept; accept = send & ready on a posedge
//  tx       out  1          serial line, idles high; registered
//  busy     out  1          high while a frame is on the line (START..STOP)
//  tx_done  out  1          one-cycle pulse in the last cycle of the final stop bit
// BEHAVIOUR
//  - Reset (async assert, sync release): tx=1, ready=1, busy=0, tx_done=0, state=IDLE, all counters 0, FIFO empty.
//  - Reset mid-frame: tx returns to 1 immediately; the frame and all FIFO contents are discarded; no tx_done.
//  - FSM states: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE (or -> START, see below).
//  - Every bit (start, data, parity, each stop bit) holds tx for exactly BAUD_COUNT cycles.
//  - Baud counter: width $clog2(BAUD_COUNT); loads BAUD_COUNT-1 at each bit start; the bit ends when it reaches 0.
//  - Bit index counter: width $clog2(DATA_BITS+1); in STOP it also counts stop bits.
//  - Word source: without FIFO, the word accepted from send; with FIFO, the FIFO head.
//  - Accept in IDLE (with a word available): word latched into shift reg; START entered next posedge; tx=0 from that edge.
//  - Latency: send high at edge N -> tx falls at edge N+1.
//  - Parity is computed over the latched word at latch time:
//      odd:  parity bit = ~^data
//      even: parity bit = ^data
//  - End of frame, last cycle of final stop bit: tx_done=1.
//      Next state is START if another word is available (FIFO build only), else IDLE.
//      In IDLE, tx=1 and busy=0.
//  - send while ready=0: ignored; data_in is not sampled; no error flag.
//  - data_in changing after accept has no effect on the frame in flight.
// CONFIGURATION
//  Macro UART_TX_FIFO_EN:
//  - Defined:
//      FIFO_DEPTH-entry FIFO in front of the serialiser; ready = !fifo_full.
//      Accepts are allowed during a frame.
//      A frame that ends with the FIFO non-empty goes straight to START of the next word with zero idle cycles.
//      Simultaneous push and pop when full is not possible (ready=0).
//      Simultaneous push and pop when non-full: both happen; occupancy is unchanged.
//  - Undefined: no FIFO; ready = (state==IDLE) & ~tx_done.
//      So at least one idle cycle follows every frame.
// STRUCTURE
//  - Package uart_pkg:
//      state enum: IDLE, START, DATA, PARITY, STOP
//      parity localparams: PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2
//      function baud_count(clk_freq, baud_rate)
//  - Sub-module uart_baud_gen: reload/down-counter emitting bit_end.
//      Reload is asserted on frame start.
//      Reused by the planned RX block.
//  - FIFO: inline under `ifdef, circular buffer with ptr-width+1 occupancy logic.
// TESTING
//  Bench uses CLK_FREQ=40, BAUD_RATE=10 (BAUD_COUNT=4); reset asserted mid-sim at least once.
//  1. 8N1, send 0xA5 -> tx: 0 (4 cyc), then 1,0,1,0,0,1,0,1 (4 cyc each), then 1 (4 cyc).
//     tx_done at cycle 40 after accept; ready back the cycle after.
//  2. DATA_BITS=7, PARITY=2 (even), STOP_BITS=2, send 0x53 -> 7 data bits 1,1,0,0,1,0,1; parity=0; two stop bits.
//     Frame length 44 cycles.
//  3. PARITY=1 (odd), send 0x00 -> parity bit 1; send 0xFF -> parity bit 1 (8 ones -> odd requires 1).
//  4. UART_TX_FIFO_EN, FIFO_DEPTH=4: burst 5 sends 0x11..0x15 on consecutive cycles ->
//     first 5 accepted (1 in flight + 4 queued); 6th held off by ready=0.
//     Frames are contiguous with no idle cycle between stop and the next start.
//  5. Assert rst_n low at data bit 3 of 0x3C -> tx=1 the same cycle, ready=1 after release, no tx_done.
//     Next send 0x01 produces a clean frame.
//  6. send held high while ready=0 (no FIFO) with data_in toggling -> in-flight frame bits unchanged.
//     Exactly one new frame starts after tx_done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: FSM state encoding, parity modes, baud divisor.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    function automatic int unsigned baud_count(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: reloads to COUNT-1 on a frame start or at each bit end,
// and flags the last clk cycle of every bit while enabled.
module uart_baud_gen #(
    parameter int unsigned COUNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    input  logic en,
    output logic bit_end
);

    localparam int unsigned W = $clog2(COUNT);
    localparam logic [W-1:0] LAST = W'(COUNT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (reload || bit_end) begin
            cnt <= LAST;
        end else if (en) begin
            cnt <= cnt - W'(1);
        end
    end

    assign bit_end = en && (cnt == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, DATA_BITS LSB first, optional parity, 1-2 stop bits.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry word FIFO in front for back-to-back frames.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 send,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned BAUD_COUNT = baud_count(CLK_FREQ, BAUD_RATE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    generate
        if (BAUD_COUNT < 2) begin : g_bad_baud
            $error("uart_tx_cfg: CLK_FREQ/BAUD_RATE must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_tx_cfg: DATA_BITS must be 5..9");
        end
        if (PARITY > PAR_EVEN) begin : g_bad_parity
            $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
            $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2 >= 2");
        end
    endgenerate

    state_t               state;
    logic [DATA_BITS-1:0] shift;
    logic [BW-1:0]        bit_idx;
    logic                 par_bit;
    logic                 bit_end;
    logic                 baud_en;
    logic                 accept;
    logic                 load;
    logic                 frame_end;
    logic [DATA_BITS-1:0] load_word;

    assign accept    = send && ready;
    assign baud_en   = (state != StIdle);
    assign frame_end = (state == StStop) && bit_end && (bit_idx == STOP_LAST);

    uart_baud_gen #(
        .COUNT(BAUD_COUNT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .reload (load),
        .en     (baud_en),
        .bit_end(bit_end)
    );

`ifdef UART_TX_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 empty;
    logic                 full;
    logic                 bypass;
    logic                 push;
    logic                 pop;

    assign empty = (count == '0);
    assign full  = (count == (AW + 1)'(FIFO_DEPTH));
    assign ready = !full;

    // An idle serialiser with nothing queued takes the word straight from data_in.
    assign bypass    = accept && (state == StIdle) && empty;
    assign push      = accept && !bypass;
    assign pop       = !empty && ((state == StIdle) || frame_end);
    assign load      = bypass || pop;
    assign load_word = pop ? mem[rd_ptr] : data_in;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end
`else
    // Held low during the tx_done cycle so every frame is followed by an idle cycle.
    assign ready     = (state == StIdle) && !tx_done;
    assign load      = accept;
    assign load_word = data_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            shift   <= '0;
            bit_idx <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            // Pin outputs trail the state by one cycle, so each state period maps onto one bit.
            case (state)
                StStart:  tx <= 1'b0;
                StData:   tx <= shift[0];
                StParity: tx <= par_bit;
                default:  tx <= 1'b1;
            endcase
            busy    <= (state != StIdle);
            tx_done <= frame_end;

            if (load) begin
                shift   <= load_word;
                par_bit <= (PARITY == PAR_ODD) ? ~^load_word : ^load_word;
            end

            case (state)
                StIdle: begin
                    if (load) begin
                        state <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        state   <= StData;
                        bit_idx <= '0;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shift <= shift >> 1;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY != PAR_NONE) ? StParity : StStop;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state <= StStop;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            state   <= load ? StStart : StIdle;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
